error_accumulator_engine: RTL and testbench
===========================================

// Module: error_accumulator_engine
// PURPOSE
//  Parametrised successor to the linear-regression error calculator.
//  - For each stored sample i, computes e_i = y_i - (b0 + b1*x_i) in signed fixed point.
//  - Writes e_i to the error memory.
//  - Accumulates sum_e and sum_ex (the gradient terms for b0/b1 update).
//  - Sits between the sample memories and the coefficient-update unit; start/done handshake to top-level CU.
// PARAMETERS
//  DATA_W  16   width of x, y, b0, b1, e (signed, two's complement)
//  FRAC    8    fractional bits of all fixed-point operands
//  N_MAX   150  max sample count; ADDR_W = $clog2(N_MAX)
//  ACC_W   32   width of sum_e / sum_ex accumulators (signed)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous active-high reset
//  start      in   1        begin pass; sampled only in IDLE
//  n_samples  in   ADDR_W+1 sample count, captured at start
//  b0, b1     in   DATA_W   coefficients, captured at start
//  mem_addr   out  ADDR_W   shared read address for x/y memories
//  mem_rd     out  1        read strobe; x_data/y_data valid next cycle
//  x_data     in   DATA_W   x sample (valid cycle after mem_rd)
//  y_data     in   DATA_W   y sample (valid cycle after mem_rd)
//  err_we     out  1        error-memory write enable
//  err_addr   out  ADDR_W   error-memory write address
//  err_data   out  DATA_W   e_i
//  sum_e      out  ACC_W    sum of e_i
//  sum_ex     out  ACC_W    sum of (e_i*x_i)>>>FRAC
//  busy       out  1        high in READ/CALC/WRITE
//  done       out  1        one-cycle pulse at end of pass
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; counter, captured n/b0/b1, sums cleared.
//  - FSM (Moore outputs):
//      IDLE -> READ  on start with n>0, or DONE on start with n=0. Sums cleared, n/b0/b1 latched.
//      READ:  mem_rd=1, mem_addr=i -> CALC.
//      CALC:  register x,y; compute e -> WRITE.
//      WRITE: err_we=1, err_addr=i, err_data=e; add to sums.
//             Then DONE if i==n-1, else i++ -> READ.
//      DONE:  done=1 for one cycle -> IDLE.
//  - Timing: start high in cycle 0; sample i in cycles 3i+1..3i+3; done high in cycle 3n+1.
//    n=0: done in cycle 1, no memory access, sums 0.
//  - n_samples > N_MAX is clamped to N_MAX.
//  - start while not IDLE is ignored. start in the DONE cycle is ignored; a new pass needs start in IDLE.
//  - Arithmetic:
//      p  = (b1*x)>>>FRAC, full 2*DATA_W signed product, arithmetic shift.
//      e  = y - (b0 + p), truncated (wrap) to DATA_W.
//      ex = (e*x)>>>FRAC, sign-extended to ACC_W.
//      Accumulators wrap modulo 2^ACC_W; no saturation.
//  - sum_e/sum_ex hold their final value after done until the next accepted start.
//  - Reset mid-pass: immediate return to IDLE with everything cleared. No partial done.
//    Error-memory contents already written are not restored.
//  - Inputs x_data/y_data are ignored outside CALC.
// TESTING
//  1. Single sample, FRAC=8: n=1, b0=0x0100, b1=0x0200, x=0x0300, y=0x0800
//     -> err_data=0x0100 at err_addr 0; sum_e=0x100, sum_ex=0x300; done in cycle 4.
//  2. Four samples with y=b0+b1*x exactly -> four writes of 0, sums 0, done in cycle 13.
//  3. Negative error: b0=0, b1=0x0100, x=0x0200, y=0x0100
//     -> err_data=0xFF00; sum_e=-256; sum_ex=-512 (0xFFFFFE00).
//  4. n=0 -> no mem_rd/err_we; done in cycle 1; sums 0.
//     start pulsed during a busy pass -> ignored, pass length unchanged.
//  5. n=N_MAX=150 with all e=0x7F00 -> addresses 0..149 each written once;
//     sum_e=150*0x7F00; done in cycle 451. n=200 also clamps to 150 writes.
//  6. rst asserted in CALC of sample 2 -> outputs 0 asynchronously, no done.
//     A new start then runs a full clean pass.

Source files
------------

// File: rtl/error_accumulator_engine_if.sv
// Bus between the error accumulator engine and its neighbours: pass control
// from the CU, the shared x/y sample-memory read port and the error-memory write port.
interface error_accumulator_engine_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int ACC_W  = 32
);
    // start is accepted only while the engine is idle; done is a one-cycle pulse.
    // mem_rd qualifies mem_addr, and x_data/y_data must be valid the following cycle.
    // err_we qualifies err_addr/err_data. There is no back-pressure on either memory port.
    logic              start;
    logic [ADDR_W:0]   n_samples;
    logic [DATA_W-1:0] b0;
    logic [DATA_W-1:0] b1;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [DATA_W-1:0] x_data;
    logic [DATA_W-1:0] y_data;
    logic              err_we;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;
    logic [ACC_W-1:0]  sum_e;
    logic [ACC_W-1:0]  sum_ex;
    logic              busy;
    logic              done;

    modport slave (
        input  start, n_samples, b0, b1, x_data, y_data,
        output mem_addr, mem_rd, err_we, err_addr, err_data, sum_e, sum_ex, busy, done
    );

    modport master (
        output start, n_samples, b0, b1, x_data, y_data,
        input  mem_addr, mem_rd, err_we, err_addr, err_data, sum_e, sum_ex, busy, done
    );
endinterface

// File: rtl/error_accumulator_engine.sv
// Computes e_i = y_i - (b0 + b1*x_i) for every stored sample, writes it to the
// error memory and accumulates sum_e and sum_ex for the coefficient-update unit.
module error_accumulator_engine #(
    parameter int DATA_W = 16,
    parameter int FRAC   = 8,
    parameter int N_MAX  = 150,
    parameter int ACC_W  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    error_accumulator_engine_if.slave        bus_io,
    output logic [2:0]                       dbg_state_o
);
    localparam int ADDR_W = $clog2(N_MAX);
    localparam int NW     = ADDR_W + 1;
    localparam int PW     = 2 * DATA_W;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state_q;
    logic [ADDR_W-1:0]        idx_q;
    logic [ADDR_W-1:0]        mem_addr_q;
    logic [ADDR_W-1:0]        err_addr_q;
    logic [NW-1:0]            n_q;
    logic signed [DATA_W-1:0] b0_q;
    logic signed [DATA_W-1:0] b1_q;
    logic signed [DATA_W-1:0] x_q;
    logic signed [DATA_W-1:0] err_data_q;
    logic [ACC_W-1:0]         sum_e_q;
    logic [ACC_W-1:0]         sum_ex_q;
    logic                     mem_rd_q;
    logic                     err_we_q;
    logic                     busy_q;
    logic                     done_q;

    logic [NW-1:0]            n_clamp;
    logic signed [DATA_W-1:0] x_s;
    logic signed [DATA_W-1:0] y_s;
    logic signed [DATA_W-1:0] e_calc;
    logic signed [PW-1:0]     bx_prod;
    logic signed [PW-1:0]     ex_prod;
    logic                     last_sample;

    assign n_clamp = (bus_io.n_samples > NW'(N_MAX)) ? NW'(N_MAX) : bus_io.n_samples;
    assign x_s     = bus_io.x_data;
    assign y_s     = bus_io.y_data;

    // Full-width products; the error itself wraps to DATA_W after the shift.
    assign bx_prod     = PW'(b1_q) * PW'(x_s);
    assign e_calc      = y_s - b0_q - DATA_W'(bx_prod >>> FRAC);
    assign ex_prod     = PW'(err_data_q) * PW'(x_q);
    assign last_sample = ({1'b0, idx_q} == n_q - NW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            mem_addr_q <= '0;
            err_addr_q <= '0;
            n_q        <= '0;
            b0_q       <= '0;
            b1_q       <= '0;
            x_q        <= '0;
            err_data_q <= '0;
            sum_e_q    <= '0;
            sum_ex_q   <= '0;
            mem_rd_q   <= 1'b0;
            err_we_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            mem_rd_q <= 1'b0;
            err_we_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus_io.start) begin
                        n_q      <= n_clamp;
                        b0_q     <= bus_io.b0;
                        b1_q     <= bus_io.b1;
                        idx_q    <= '0;
                        sum_e_q  <= '0;
                        sum_ex_q <= '0;
                        if (n_clamp == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= S_READ;
                            mem_rd_q   <= 1'b0 | 1'b1;
                            mem_addr_q <= '0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    state_q <= S_CALC;
                end
                S_CALC: begin
                    x_q        <= x_s;
                    err_data_q <= e_calc;
                    err_addr_q <= idx_q;
                    err_we_q   <= 1'b1;
                    state_q    <= S_WRITE;
                end
                S_WRITE: begin
                    sum_e_q  <= sum_e_q + ACC_W'(err_data_q);
                    sum_ex_q <= sum_ex_q + ACC_W'(ex_prod >>> FRAC);
                    if (last_sample) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q      <= idx_q + ADDR_W'(1);
                        mem_addr_q <= idx_q + ADDR_W'(1);
                        mem_rd_q   <= 1'b1;
                        state_q    <= S_READ;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.mem_addr = mem_addr_q;
    assign bus_io.mem_rd   = mem_rd_q;
    assign bus_io.err_we   = err_we_q;
    assign bus_io.err_addr = err_addr_q;
    assign bus_io.err_data = err_data_q;
    assign bus_io.sum_e    = sum_e_q;
    assign bus_io.sum_ex   = sum_ex_q;
    assign bus_io.busy     = busy_q;
    assign bus_io.done     = done_q;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_error_accumulator_engine.sv
// Randomised bench for error_accumulator_engine: a sample-memory responder, driver
// tasks, a reference model feeding expected queues and a negedge monitor.
module tb_error_accumulator_engine;
    localparam int DATA_W = 16;
    localparam int FRAC   = 8;
    localparam int N_MAX  = 150;
    localparam int ADDR_W = 8;
    localparam int ACC_W  = 32;
    localparam int RD_W   = 32 + ADDR_W;
    localparam int WR_W   = 32 + ADDR_W + DATA_W;
    localparam int DN_W   = 32 + 2 * ACC_W;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    logic [DATA_W-1:0] x_mem [N_MAX];
    logic [DATA_W-1:0] y_mem [N_MAX];

    logic [RD_W-1:0] exp_rd_q [$];
    logic [WR_W-1:0] exp_q [$];
    logic [DN_W-1:0] exp_dn_q [$];
    logic [RD_W-1:0] rd_e;
    logic [WR_W-1:0] wr_e;
    logic [DN_W-1:0] dn_e;
    logic [ACC_W-1:0] last_se;
    logic [ACC_W-1:0] last_sx;

    error_accumulator_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

    error_accumulator_engine #(
        .DATA_W(DATA_W), .FRAC(FRAC), .N_MAX(N_MAX), .ACC_W(ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus_io(bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Sample memory: one-cycle read latency, garbage whenever not read.
    always @(posedge clk) begin
        if (bus.mem_rd) begin
            bus.x_data <= x_mem[bus.mem_addr];
            bus.y_data <= y_mem[bus.mem_addr];
        end else begin
            bus.x_data <= 16'($urandom);
            bus.y_data <= 16'($urandom);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: strobe seen in cycle %0d, expected none", name, cyc);
    endtask

    // ---------------- reference model ----------------
    function automatic void push_model(input int n, input logic [15:0] b0, input logic [15:0] b1,
                                       input int c0);
        longint se, sx, xv, yv, b0v, b1v, p, ev, exv;
        logic [63:0] t;
        se  = 0;
        sx  = 0;
        b0v = longint'($signed(b0));
        b1v = longint'($signed(b1));
        for (int i = 0; i < n; i++) begin
            xv  = longint'($signed(x_mem[i]));
            yv  = longint'($signed(y_mem[i]));
            p   = (b1v * xv) >>> FRAC;
            t   = yv - (b0v + p);
            ev  = longint'($signed(t[15:0]));
            exv = (ev * xv) >>> FRAC;
            se  = se + ev;
            sx  = sx + exv;
            exp_rd_q.push_back({32'(c0 + 3 * i + 1), ADDR_W'(i)});
            exp_q.push_back({32'(c0 + 3 * i + 3), ADDR_W'(i), t[15:0]});
        end
        last_se = se[31:0];
        last_sx = sx[31:0];
        exp_dn_q.push_back({32'(c0 + 3 * n + 1), last_se, last_sx});
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_rd) begin
                check("busy_in_read", bus.busy, 1);
                if (exp_rd_q.size() == 0) unexpected("mem_rd");
                else begin
                    rd_e = exp_rd_q.pop_front();
                    check("mem_rd_cyc_addr", {cyc, bus.mem_addr}, rd_e);
                end
            end
            if (bus.err_we) begin
                check("busy_in_write", bus.busy, 1);
                if (exp_q.size() == 0) unexpected("err_we");
                else begin
                    wr_e = exp_q.pop_front();
                    check("err_cyc_addr_data", {cyc, bus.err_addr, bus.err_data}, wr_e);
                end
            end
            if (bus.done) begin
                check("busy_at_done", bus.busy, 0);
                if (exp_dn_q.size() == 0) unexpected("done");
                else begin
                    dn_e = exp_dn_q.pop_front();
                    check("done_cyc_sums", {cyc, bus.sum_e, bus.sum_ex}, dn_e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic bit queues_empty();
        return exp_rd_q.size() == 0 && exp_q.size() == 0 && exp_dn_q.size() == 0;
    endfunction

    task automatic flush();
        exp_rd_q.delete();
        exp_q.delete();
        exp_dn_q.delete();
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            x_mem[i] = 16'($urandom);
            y_mem[i] = 16'($urandom);
        end
    endtask

    // poke: cycle (relative to the start cycle) in which start is pulsed again, -1 for none.
    task automatic run_pass(input int n_req, input logic [15:0] b0, input logic [15:0] b1,
                            input int poke);
        int n, c0, rel;
        n = (n_req > N_MAX) ? N_MAX : n_req;
        @(posedge clk); #1;
        c0 = cyc;
        push_model(n, b0, b1, c0);
        bus.start     = 1'b1;
        bus.n_samples = 9'(n_req);
        bus.b0        = b0;
        bus.b1        = b1;
        for (int k = 0; k < 600; k++) begin
            @(posedge clk); #1;
            rel = cyc - c0;
            bus.start = (rel == poke);
            if (k == 0) begin
                bus.n_samples = 9'($urandom);
                bus.b0        = 16'($urandom);
                bus.b1        = 16'($urandom);
            end
            if (queues_empty() && rel > poke) break;
        end
        bus.start = 1'b0;
        if (!queues_empty()) begin
            n_checks++;
            n_fail++;
            $display("FAIL pass_timeout: %0d/%0d/%0d items outstanding, expected 0",
                     exp_rd_q.size(), exp_q.size(), exp_dn_q.size());
            flush();
        end else begin
            check("sum_e_hold", bus.sum_e, last_se);
            check("sum_ex_hold", bus.sum_ex, last_sx);
            check("busy_after_done", bus.busy, 0);
        end
    endtask

    task automatic run_abort();
        int c0, rel;
        logic [15:0] b0, b1;
        b0 = 16'($urandom);
        b1 = 16'($urandom);
        fill_random(5);
        @(posedge clk); #1;
        c0 = cyc;
        push_model(5, b0, b1, c0);
        bus.start     = 1'b1;
        bus.n_samples = 9'd5;
        bus.b0        = b0;
        bus.b1        = b1;
        rel = 0;
        for (int k = 0; k < 20 && rel != 8; k++) begin
            @(posedge clk); #1;
            rel = cyc - c0;
            bus.start = 1'b0;
        end
        // Cycle 8 is CALC of sample 2; reset lands mid-cycle.
        #2 rst = 1'b1;
        #1;
        check("abort_mem_rd", bus.mem_rd, 0);
        check("abort_err_we", bus.err_we, 0);
        check("abort_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_sum_e", bus.sum_e, 0);
        check("abort_sum_ex", bus.sum_ex, 0);
        check("abort_err_data", bus.err_data, 0);
        check("abort_mem_addr", bus.mem_addr, 0);
        check("abort_state", dbg_state, 0);
        check("abort_writes_left", exp_q.size(), 3);
        check("abort_reads_left", exp_rd_q.size(), 2);
        flush();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [63:0] t;
        int n, poke;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.n_samples = '0;
        bus.b0        = '0;
        bus.b1        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_err_we", bus.err_we, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_sum_e", bus.sum_e, 0);
        check("rst_sum_ex", bus.sum_ex, 0);
        check("rst_err_data", bus.err_data, 0);
        rst = 1'b0;

        // Single sample, positive error.
        x_mem[0] = 16'h0300;
        y_mem[0] = 16'h0800;
        run_pass(1, 16'h0100, 16'h0200, -1);
        check("t1_sum_e", bus.sum_e, 32'h0000_0100);
        check("t1_sum_ex", bus.sum_ex, 32'h0000_0300);

        // Four samples exactly on the line.
        for (int i = 0; i < 4; i++) begin
            x_mem[i] = 16'($urandom_range(0, 16'h0400));
            t = longint'($signed(16'h0040)) + ((longint'($signed(16'h0180)) * longint'($signed(x_mem[i]))) >>> FRAC);
            y_mem[i] = t[15:0];
        end
        run_pass(4, 16'h0040, 16'h0180, -1);
        check("t2_sum_e", bus.sum_e, 0);
        check("t2_sum_ex", bus.sum_ex, 0);

        // Negative error.
        x_mem[0] = 16'h0200;
        y_mem[0] = 16'h0100;
        run_pass(1, 16'h0000, 16'h0100, -1);
        check("t3_sum_e", bus.sum_e, 32'hFFFF_FF00);
        check("t3_sum_ex", bus.sum_ex, 32'hFFFF_FE00);

        // Empty pass, start during busy, start during DONE.
        run_pass(0, 16'h1234, 16'h5678, -1);
        check("t4_sum_e", bus.sum_e, 0);
        fill_random(3);
        run_pass(3, 16'($urandom), 16'($urandom), 4);
        fill_random(2);
        run_pass(2, 16'($urandom), 16'($urandom), 7);

        // Full memory with a constant error, then a clamped request.
        for (int i = 0; i < N_MAX; i++) begin
            x_mem[i] = 16'($urandom);
            y_mem[i] = 16'h7F00;
        end
        run_pass(N_MAX, 16'h0000, 16'h0000, -1);
        check("t5_sum_e", bus.sum_e, 32'(150 * 32'h7F00));
        fill_random(N_MAX);
        run_pass(200, 16'($urandom), 16'($urandom), -1);

        // Reset mid-pass, then a clean pass.
        run_abort();
        fill_random(6);
        run_pass(6, 16'($urandom), 16'($urandom), -1);

        // Random passes.
        for (int r = 0; r < 8; r++) begin
            n = $urandom_range(1, 12);
            poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 3 * n)) : -1;
            fill_random(n);
            run_pass(n, 16'($urandom), 16'($urandom), poke);
        end

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
